hazard_unit: RTL and testbench

//  Pipeline hazard producer for the 5-stage core. Drives the hazard request that the stall-extension FSM consumes.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_mc_timer.sv | 61 ++++++
 rtl/hazard_unit.sv | 93 +++++++++
 tb/tb_hazard_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forwarding selects and the multi-cycle FSM state.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

    typedef enum logic {
        IDLE   = 1'b0,
        MCBUSY = 1'b1
    } haz_state_t;

    localparam int unsigned REG_AW_DEF = 5;

    // The Memory stage holds the younger result, so it wins over Writeback.
    function automatic fwd_t fwd_sel(input logic hit_mem, input logic hit_wb);
        if (hit_mem)     return FWD_MEM;
        else if (hit_wb) return FWD_WB;
        else             return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_mc_timer.sv
// Occupancy timer for multi-cycle EX ops: holds EX for MC_LAT cycles including the start cycle.
module hazard_mc_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 4
) (
    input  logic clk,
    input  logic hazreset,
    input  logic mcstartE,
    output logic mcb,
    output logic busy,
    output logic last
);

    localparam int unsigned CNT_AW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam bit          MC_EN  = (MC_LAT > 1);
    // The start cycle counts as one EX cycle, so MCBUSY covers the remaining MC_LAT-1.
    localparam logic [CNT_AW-1:0] CNT_INIT = CNT_AW'((MC_LAT > 1) ? MC_LAT - 2 : 0);

    haz_state_t        state_q, state_d;
    logic [CNT_AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (hazreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcb     = 1'b0;
        busy    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mcstartE && MC_EN) begin
                    state_d = MCBUSY;
                    cnt_d   = CNT_INIT;
                    mcb     = 1'b1;
                end
            end
            MCBUSY: begin
                mcb  = 1'b1;
                busy = 1'b1;
                if (cnt_q == '0) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX forwarding, load-use stall, multi-cycle hold and branch flush.
// Optional perf counters (stall_cycles, flush_events) are built when HAZ_PERF_EN is defined.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned MC_LAT = 4
`ifdef HAZ_PERF_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              hazreset,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              loadE,
    input  logic              pcsrcE,
    input  logic              mcstartE,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              haz_out,
    output logic              busy
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
`endif
);

    logic mcb, last, lwstall;

    hazard_mc_timer #(
        .MC_LAT (MC_LAT)
    ) u_mc_timer (
        .clk      (clk),
        .hazreset (hazreset),
        .mcstartE (mcstartE),
        .mcb      (mcb),
        .busy     (busy),
        .last     (last)
    );

    always_comb begin
        forwardAE = fwd_sel(regwriteM && (rdM != '0) && (rdM == rs1E),
                            regwriteW && (rdW != '0) && (rdW == rs1E));
        forwardBE = fwd_sel(regwriteM && (rdM != '0) && (rdM == rs2E),
                            regwriteW && (rdW != '0) && (rdW == rs2E));
    end

    always_comb begin
        lwstall = loadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
        stallF  = lwstall || mcb;
        stallD  = lwstall || mcb;
        stallE  = mcb;
        // The bubble into MEM stops on the op's final EX cycle so its result can advance.
        flushM  = mcb && !last;
        flushD  = pcsrcE && !mcb;
        flushE  = (lwstall || pcsrcE) && !mcb;
        haz_out = lwstall || mcb;
    end

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (hazreset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stallF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flushE && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (MC_LAT=4); perf counters checked when HAZ_PERF_EN is defined.
module tb_hazard_unit;

    localparam int unsigned AW = 5;

    typedef struct {
        logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic          regwriteM, regwriteW, loadE, pcsrcE, mcstartE;
    } in_t;

    typedef struct {
        in_t         in;
        logic [11:0] exp;
        string       name;
    } vec_t;

    // Expected output packing: {fwdA, fwdB, stallF, stallD, stallE, flushD, flushE, flushM, haz, busy}
    localparam logic [11:0] E0      = 12'b00_00_0000_0000;
    localparam logic [11:0] MC_ON   = 12'b00_00_1110_0110;
    localparam logic [11:0] MC_MID  = 12'b00_00_1110_0111;
    localparam logic [11:0] MC_LAST = 12'b00_00_1110_0011;
    localparam logic [11:0] LW      = 12'b00_00_1100_1010;
    localparam logic [11:0] BR      = 12'b00_00_0001_1000;
    localparam logic [11:0] LWBR    = 12'b00_00_1101_1010;

    logic          clk = 1'b0;
    logic          hazreset;
    logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          regwriteM, regwriteW, loadE, pcsrcE, mcstartE;
    logic [1:0]    forwardAE, forwardBE;
    logic          stallF, stallD, stallE, flushD, flushE, flushM, haz_out, busy;
`ifdef HAZ_PERF_EN
    logic [3:0]    stall_cycles, flush_events;
`endif

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    hazard_unit #(
        .REG_AW (AW),
        .MC_LAT (4)
`ifdef HAZ_PERF_EN
        ,
        .CNT_W  (4)
`endif
    ) dut (
        .clk       (clk),
        .hazreset  (hazreset),
        .rs1D      (rs1D),
        .rs2D      (rs2D),
        .rs1E      (rs1E),
        .rs2E      (rs2E),
        .rdE       (rdE),
        .rdM       (rdM),
        .rdW       (rdW),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .loadE     (loadE),
        .pcsrcE    (pcsrcE),
        .mcstartE  (mcstartE),
        .forwardAE (forwardAE),
        .forwardBE (forwardBE),
        .stallF    (stallF),
        .stallD    (stallD),
        .stallE    (stallE),
        .flushD    (flushD),
        .flushE    (flushE),
        .flushM    (flushM),
        .haz_out   (haz_out),
        .busy      (busy)
`ifdef HAZ_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Scoreboard consumer: one expected record per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [11:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, {20'b0, forwardAE, forwardBE, stallF, stallD, stallE,
                      flushD, flushE, flushM, haz_out, busy}, {20'b0, e});
        end
    end

    function automatic in_t mk(input logic [AW-1:0] r1d, r2d, r1e, r2e, rde, rdm, rdw,
                               input logic rwm, rww, ld, pc, mc);
        in_t t;
        t.rs1D = r1d; t.rs2D = r2d; t.rs1E = r1e; t.rs2E = r2e;
        t.rdE = rde; t.rdM = rdm; t.rdW = rdw;
        t.regwriteM = rwm; t.regwriteW = rww; t.loadE = ld; t.pcsrcE = pc; t.mcstartE = mc;
        return t;
    endfunction

    task automatic drive(input in_t t, input logic rst, input logic [11:0] exp,
                         input string name);
        @(posedge clk);
        #1;
        hazreset  = rst;
        rs1D = t.rs1D; rs2D = t.rs2D; rs1E = t.rs1E; rs2E = t.rs2E;
        rdE = t.rdE; rdM = t.rdM; rdW = t.rdW;
        regwriteM = t.regwriteM; regwriteW = t.regwriteW;
        loadE = t.loadE; pcsrcE = t.pcsrcE; mcstartE = t.mcstartE;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[$];
        in_t   idle, mc, lwbr;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mc   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        lwbr = mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 1);

        //            rs1D rs2D rs1E rs2E rdE rdM rdW rwM rwW ld pc mc
        vecs.push_back('{mk(0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0), 12'b10_00_0000_0000, "fwd_mem"});
        vecs.push_back('{mk(0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, 0), 12'b01_00_0000_0000, "fwd_wb"});
        vecs.push_back('{mk(0, 0, 5, 0, 0, 5, 0, 0, 1, 0, 0, 0), E0, "fwd_rf"});
        vecs.push_back('{mk(0, 0, 3, 5, 0, 5, 3, 1, 1, 0, 0, 0), 12'b01_10_0000_0000, "fwd_split"});
        vecs.push_back('{mk(0, 0, 4, 6, 0, 4, 6, 1, 1, 0, 0, 0), 12'b10_01_0000_0000, "fwd_split2"});
        vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), E0, "fwd_x0"});
        vecs.push_back('{mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0), LW, "lw_rs2"});
        vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), E0, "lw_rd0"});
        vecs.push_back('{mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0), LW, "lw_rs1"});
        vecs.push_back('{mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0), E0, "lw_noload"});
        vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), BR, "branch"});
        vecs.push_back('{mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0), LWBR, "lw_branch"});

        hazreset = 1'b1;
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
        regwriteM = 0; regwriteW = 0; loadE = 0; pcsrcE = 0; mcstartE = 0;
        repeat (2) @(posedge clk);
        drive(idle, 0, E0, "reset");

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i].in, 0, vecs[i].exp, vecs[i].name);
        drive(idle, 0, E0, "lw_one_cycle");

        // Full multi-cycle op.
        drive(mc,   0, MC_ON,   "mc_c1");
        drive(idle, 0, MC_MID,  "mc_c2");
        drive(idle, 0, MC_MID,  "mc_c3");
        drive(idle, 0, MC_LAST, "mc_c4");
        drive(idle, 0, E0,      "mc_done");

        // Load-use, branch and a second start during MCBUSY are all ignored.
        drive(mc,   0, MC_ON,   "mci_c1");
        drive(idle, 0, MC_MID,  "mci_c2");
        drive(lwbr, 0, MC_MID,  "mci_c3_ignored");
        drive(idle, 0, MC_LAST, "mci_c4");
        drive(idle, 0, E0,      "mci_done");

        // Reset mid-op abandons it; a new op gets the full latency.
        drive(mc,   0, MC_ON,   "rmc_c1");
        drive(idle, 1, MC_MID,  "rmc_c2_reset");
        drive(idle, 0, E0,      "rmc_abandoned");
        drive(mc,   0, MC_ON,   "rmc2_c1");
        drive(idle, 0, MC_MID,  "rmc2_c2");
        drive(idle, 0, MC_MID,  "rmc2_c3");
        drive(idle, 0, MC_LAST, "rmc2_c4");
        drive(idle, 0, E0,      "rmc2_done");

`ifdef HAZ_PERF_EN
        drive(idle, 1, E0, "perf_reset");
        drive(mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0), 0, LW, "perf_lw");
        drive(mc,   0, MC_ON,   "perf_mc1");
        drive(idle, 0, MC_MID,  "perf_mc2");
        drive(idle, 0, MC_MID,  "perf_mc3");
        drive(idle, 0, MC_LAST, "perf_mc4");
        drive(idle, 0, E0,      "perf_idle");
        @(negedge clk);
        #1;
        check("perf_stall_cycles", 32'(stall_cycles), 32'd5);
        check("perf_flush_events", 32'(flush_events), 32'd1);
        for (int i = 0; i < 15; i++) drive(mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0), 0, LW, "perf_sat_lw");
        drive(idle, 0, E0, "perf_sat_idle");
        @(negedge clk);
        #1;
        check("perf_stall_sat", 32'(stall_cycles), 32'd15);
        check("perf_flush_sat", 32'(flush_events), 32'd15);
`endif

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
